// File: rtl/alu_ops.sv
// rtl/alu_ops.sv - shared opcode and state enums for alu_seq
package alu_ops;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_LLS = 4'd0,
    OP_LRS = 4'd1,
    OP_ALS = 4'd2,
    OP_ARS = 4'd3,
    OP_NOT = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_ADD = 4'd8,
    OP_SUB = 4'd9,
    OP_MUL = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add unsigned multiplier, one partial product per step
module alu_seq_mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int CW = $clog2(W) + 1;

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // prod is the accumulator including the current step, so the top can load it on the last step
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    prod     = acc_q + (mplier_q[0] ? mcand_q : '0);
    done     = step && (cnt_q == CW'(W - 1));
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
    end else if (step) begin
      acc_d    = prod;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = done ? '0 : cnt_q + 1'b1;
    end
  end

  // datapath and iteration counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshake; MUL enabled by ALU_SEQ_MUL_EN
module alu_seq
  import alu_ops::*;
#(
  parameter int W   = 8,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] opcode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           use_carry,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   y,
  output logic           c_out,
  output logic           v,
  output logic           n,
  output logic           z
);

  state_e         state_q, state_d;
  logic [W-1:0]   y_q, y_d;
  logic           c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d;
  logic [W-1:0]   r_y;
  logic           r_c, r_v;
  logic [W:0]     lsh_ext, rsh_ext, sum;
  logic [W-1:0]   b_eff;
  logic           cin, is_sub, als_v, accept, is_mul;

  // single-cycle datapath; c_q doubles as the stored carry for use_carry
  always_comb begin
    lsh_ext = {1'b0, a} << b;
    rsh_ext = {a, 1'b0} >> b;
    is_sub  = (opcode == OPW'(OP_SUB));
    cin     = use_carry ? c_q : is_sub;
    b_eff   = is_sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
    als_v   = (lsh_ext[W-1] != a[W-1]);
    for (int i = 0; i < W; i++) begin
      if ((W'(W - 1 - i) < b) && (a[i] != a[W-1])) als_v = 1'b1;
    end
    r_y = '0;
    r_c = 1'b0;
    r_v = 1'b0;
    case (opcode)
      OPW'(OP_LLS): begin r_y = lsh_ext[W-1:0]; r_c = lsh_ext[W]; end
      OPW'(OP_LRS): begin r_y = rsh_ext[W:1]; r_c = rsh_ext[0]; end
      OPW'(OP_ALS): begin r_y = lsh_ext[W-1:0]; r_c = lsh_ext[W]; r_v = als_v; end
      OPW'(OP_ARS): begin r_y = $unsigned($signed(a) >>> b); r_c = rsh_ext[0]; end
      OPW'(OP_NOT): r_y = ~a;
      OPW'(OP_AND): r_y = a & b;
      OPW'(OP_OR):  r_y = a | b;
      OPW'(OP_XOR): r_y = a ^ b;
      OPW'(OP_ADD), OPW'(OP_SUB): begin
        r_y = sum[W-1:0];
        r_c = sum[W];
        r_v = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
      end
      default: r_y = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic           mul_start, mul_done;
  logic [2*W-1:0] mul_prod;

  assign is_mul = (opcode == OPW'(OP_MUL));

  alu_seq_mul #(.W(W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .step  (state_q == S_BUSY),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`else
  assign is_mul = 1'b0;
`endif

  // handshake, next state and result/flag load
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    c_d     = c_q;
    v_d     = v_q;
    n_d     = n_q;
    z_d     = z_q;
`ifdef ALU_SEQ_MUL_EN
    mul_start = 1'b0;
`endif
    out_valid = (state_q == S_HOLD);
    in_ready  = rst_n && ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
    accept    = in_valid && in_ready;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if ((state_q == S_HOLD) && out_ready) state_d = S_IDLE;
        if (accept && is_mul) begin
          state_d = S_BUSY;
`ifdef ALU_SEQ_MUL_EN
          mul_start = 1'b1;
`endif
        end else if (accept) begin
          state_d = S_HOLD;
          y_d     = r_y;
          c_d     = r_c;
          v_d     = r_v;
          n_d     = r_y[W-1];
          z_d     = (r_y == '0);
        end
      end
      S_BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_done) begin
          state_d = S_HOLD;
          y_d     = mul_prod[W-1:0];
          c_d     = |mul_prod[2*W-1:W];
          v_d     = 1'b0;
          n_d     = mul_prod[W-1];
          z_d     = (mul_prod[W-1:0] == '0);
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and registered result/flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      c_q     <= c_d;
      v_q     <= v_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end

  assign y     = y_q;
  assign c_out = c_q;
  assign v     = v_q;
  assign n     = n_q;
  assign z     = z_q;

endmodule
